ps2_key_receiver: RTL and testbench

Synchronous PS/2 keyboard receiver that sits directly upstream of the scan-code decoder in the simple piano. It synchronizes and deglitches the raw keyboard clock and data lines into the 2.08 MHz system clock domain, then deframes 11-bit PS/2 frames and checks them. It tracks F0 (break) and E0 (extended) prefixes and presents a held-key code that the decoder turns into a note select. It replaces direct clocking of a shift register by the keyboard clock.

---
 rtl/ps2_key_receiver.sv | 235 +++++++++++++++++++++++
 tb/tb_ps2_key_receiver.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_key_receiver.sv
// ---------------------------------------------------------------------------
// ps2_key_receiver
//   PS/2 keyboard receiver running entirely in the system clock domain.
//   The raw keyboard clock/data lines are synchronized, the clock is
//   deglitched, and 11-bit frames are deframed on filtered falling edges.
//   Frames are checked (odd parity, stop bit, inter-edge timeout).
//   F0 (break) and E0 (extended) prefixes are tracked, and a held-key code
//   is maintained for the downstream scan-code decoder.
//
// Parameters
//   GLITCH_CYCLES  : cycles the synchronized kb_clk must hold a new level
//                    before the filtered clock follows (1..15)
//   TIMEOUT_CYCLES : cycles without a filtered fall that abort a frame
//
// Ports
//   clk_i          : system clock
//   reset_i        : asynchronous active-high reset
//   kb_clk_i       : raw PS/2 clock (asynchronous)
//   data_i         : raw PS/2 data  (asynchronous)
//   scan_code_o    : last accepted non-prefix code, held until next accept
//   code_valid_o   : one-cycle pulse, scan_code/is_break/is_extended valid
//   is_break_o     : accepted code was preceded by F0
//   is_extended_o  : accepted code was preceded by E0
//   frame_err_o    : one-cycle pulse on parity, stop or timeout error
//   key_active_o   : a non-extended key is currently held
//   held_code_o    : code of the held key, 0x00 when none
// ---------------------------------------------------------------------------
module ps2_key_receiver #(
  parameter int GLITCH_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 4160
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       kb_clk_i,
  input  logic       data_i,
  output logic [7:0] scan_code_o,
  output logic       code_valid_o,
  output logic       is_break_o,
  output logic       is_extended_o,
  output logic       frame_err_o,
  output logic       key_active_o,
  output logic [7:0] held_code_o
);

  localparam int          TW      = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]  GC_LAST = 4'(GLITCH_CYCLES - 1);

  localparam logic [7:0] BRK_PREFIX = 8'hF0;
  localparam logic [7:0] EXT_PREFIX = 8'hE0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DONE = 2'd2
  } state_e;

  // -------------------------------------------------------------------------
  // Synchronizers. Reset to 1 so an idle (high) line produces no edge
  // when reset is released.
  // -------------------------------------------------------------------------
  logic [1:0] kb_sync_q;
  logic [1:0] dat_sync_q;
  logic       kb_s;
  logic       dat_s;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      kb_sync_q  <= 2'b11;
      dat_sync_q <= 2'b11;
    end else begin
      kb_sync_q  <= {kb_sync_q[0], kb_clk_i};
      dat_sync_q <= {dat_sync_q[0], data_i};
    end
  end

  assign kb_s  = kb_sync_q[1];
  assign dat_s = dat_sync_q[1];

  // -------------------------------------------------------------------------
  // Clock deglitch filter. The count runs only while the synchronized clock
  // disagrees with the filtered one; any return to agreement restarts it,
  // so short pulses never reach the filtered clock.
  // -------------------------------------------------------------------------
  logic [3:0] flt_cnt_q, flt_cnt_d;
  logic       kf_q, kf_d;
  logic       kf_prev_q;
  logic       fall;

  always_comb begin
    flt_cnt_d = 4'd0;
    kf_d      = kf_q;
    if (kb_s != kf_q) begin
      if (flt_cnt_q == GC_LAST) begin
        kf_d      = ~kf_q;
        flt_cnt_d = 4'd0;
      end else begin
        flt_cnt_d = flt_cnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      flt_cnt_q <= 4'd0;
      kf_q      <= 1'b1;
      kf_prev_q <= 1'b1;
    end else begin
      flt_cnt_q <= flt_cnt_d;
      kf_q      <= kf_d;
      kf_prev_q <= kf_q;
    end
  end

  assign fall = kf_prev_q & ~kf_q;

  // -------------------------------------------------------------------------
  // Deframing FSM with registered outputs.
  //   sr_q after 10 shifts: [7:0] data byte, [8] parity, [9] stop.
  // -------------------------------------------------------------------------
  state_e        state_q;
  logic [3:0]    bit_cnt_q;
  logic [TW-1:0] timer_q;
  logic [9:0]    sr_q;
  logic          brk_pend_q;
  logic          ext_pend_q;

  logic [7:0]    scan_code_q;
  logic          code_valid_q;
  logic          is_break_q;
  logic          is_extended_q;
  logic          frame_err_q;
  logic          key_active_q;
  logic [7:0]    held_code_q;

  logic [7:0]    rx_byte;
  logic          frame_ok;

  assign rx_byte  = sr_q[7:0];
  // Odd parity over data+parity, and a high stop bit.
  assign frame_ok = (^sr_q[8:0]) & sr_q[9];

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q       <= IDLE;
      bit_cnt_q     <= 4'd0;
      timer_q       <= '0;
      sr_q          <= 10'd0;
      brk_pend_q    <= 1'b0;
      ext_pend_q    <= 1'b0;
      scan_code_q   <= 8'h00;
      code_valid_q  <= 1'b0;
      is_break_q    <= 1'b0;
      is_extended_q <= 1'b0;
      frame_err_q   <= 1'b0;
      key_active_q  <= 1'b0;
      held_code_q   <= 8'h00;
    end else begin
      // Pulses default low every cycle.
      code_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;

      unique case (state_q)
        IDLE: begin
          // A fall with data high is line noise, not a start bit.
          if (fall && !dat_s) begin
            state_q   <= RECV;
            bit_cnt_q <= 4'd0;
            timer_q   <= '0;
          end
        end

        RECV: begin
          if (fall) begin
            timer_q   <= '0;
            sr_q      <= {dat_s, sr_q[9:1]};
            bit_cnt_q <= bit_cnt_q + 4'd1;
            if (bit_cnt_q == 4'd9) state_q <= DONE;
          end else if (timer_q == TO_LAST) begin
            state_q     <= IDLE;
            frame_err_q <= 1'b1;
            brk_pend_q  <= 1'b0;
            ext_pend_q  <= 1'b0;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end

        DONE: begin
          // Single cycle; any fall seen here is ignored.
          state_q <= IDLE;
          if (!frame_ok) begin
            frame_err_q <= 1'b1;
            brk_pend_q  <= 1'b0;
            ext_pend_q  <= 1'b0;
          end else if (rx_byte == BRK_PREFIX) begin
            brk_pend_q <= 1'b1;
          end else if (rx_byte == EXT_PREFIX) begin
            ext_pend_q <= 1'b1;
          end else begin
            scan_code_q   <= rx_byte;
            is_break_q    <= brk_pend_q;
            is_extended_q <= ext_pend_q;
            code_valid_q  <= 1'b1;
            brk_pend_q    <= 1'b0;
            ext_pend_q    <= 1'b0;
            // Held-key tracking ignores extended codes entirely. A make
            // replaces whatever was held (a typematic repeat rewrites the
            // same value); a break only releases the matching key.
            if (!ext_pend_q) begin
              if (!brk_pend_q) begin
                held_code_q  <= rx_byte;
                key_active_q <= 1'b1;
              end else if (key_active_q && (held_code_q == rx_byte)) begin
                held_code_q  <= 8'h00;
                key_active_q <= 1'b0;
              end
            end
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign scan_code_o   = scan_code_q;
  assign code_valid_o  = code_valid_q;
  assign is_break_o    = is_break_q;
  assign is_extended_o = is_extended_q;
  assign frame_err_o   = frame_err_q;
  assign key_active_o  = key_active_q;
  assign held_code_o   = held_code_q;

endmodule

// File: tb/tb_ps2_key_receiver.sv
`timescale 1ns/1ps
module tb_ps2_key_receiver;

  logic       clk;
  logic       reset;
  logic       kb_clk;
  logic       data;
  logic [7:0] scan_code;
  logic       code_valid;
  logic       is_break;
  logic       is_extended;
  logic       frame_err;
  logic       key_active;
  logic [7:0] held_code;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit         err;
    logic [7:0] sc;
    logic       brk;
    logic       ext;
    logic       ka;
    logic [7:0] held;
  } exp_t;

  exp_t sb[$];

  ps2_key_receiver #(.GLITCH_CYCLES(4), .TIMEOUT_CYCLES(4160)) dut (
    .clk_i        (clk),
    .reset_i      (reset),
    .kb_clk_i     (kb_clk),
    .data_i       (data),
    .scan_code_o  (scan_code),
    .code_valid_o (code_valid),
    .is_break_o   (is_break),
    .is_extended_o(is_extended),
    .frame_err_o  (frame_err),
    .key_active_o (key_active),
    .held_code_o  (held_code)
  );

  // ~2.08 MHz
  initial clk = 1'b0;
  always #240 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic push_ok(input logic [7:0] sc, input logic brk, input logic ext,
                         input logic ka, input logic [7:0] held);
    exp_t e;
    e.err = 1'b0; e.sc = sc; e.brk = brk; e.ext = ext; e.ka = ka; e.held = held;
    sb.push_back(e);
  endtask

  task automatic push_err();
    exp_t e;
    e.err = 1'b1; e.sc = 8'h00; e.brk = 1'b0; e.ext = 1'b0; e.ka = 1'b0; e.held = 8'h00;
    sb.push_back(e);
  endtask

  // One 104-cycle (~50 us) bit: data set while clock high, low half centred.
  task automatic send_bit(input bit b, input bit glitch);
    data = b;
    if (glitch) begin
      tick(10);
      kb_clk = 1'b0;
      tick(2);
      kb_clk = 1'b1;
      tick(14);
    end else begin
      tick(26);
    end
    kb_clk = 1'b0;
    tick(52);
    kb_clk = 1'b1;
    tick(26);
  endtask

  task automatic send_frame(input logic [7:0] code, input bit bad_par = 0,
                            input bit bad_stop = 0, input bit glitch = 0);
    logic par;
    par = ~(^code) ^ bad_par;
    send_bit(1'b0, glitch);
    for (int i = 0; i < 8; i++) send_bit(code[i], glitch);
    send_bit(par, glitch);
    send_bit(~bad_stop, glitch);
    data = 1'b1;
    tick(20);
  endtask

  // Scoreboard monitor: every output pulse must match the next expectation.
  always @(negedge clk) begin
    if (!reset && (code_valid || frame_err)) begin
      checks++;
      assert (!(code_valid && frame_err)) else begin
        errors++;
        $error("FAIL pulse_overlap: observed both high expected exclusive");
      end
      if (sb.size() == 0) begin
        checks++;
        assert (1'b0) else begin
          errors++;
          $error("FAIL unexpected_pulse: observed cv=%0b fe=%0b expected none", code_valid, frame_err);
        end
      end else begin
        exp_t e;
        e = sb.pop_front();
        checks++;
        assert (frame_err === e.err && code_valid === !e.err) else begin
          errors++;
          $error("FAIL pulse_kind: observed fe=%0b cv=%0b expected fe=%0b", frame_err, code_valid, e.err);
        end
        if (!e.err) begin
          checks++;
          assert ({scan_code, is_break, is_extended, key_active, held_code} ===
                  {e.sc, e.brk, e.ext, e.ka, e.held}) else begin
            errors++;
            $error("FAIL accept: observed sc=%h brk=%0b ext=%0b ka=%0b held=%h expected sc=%h brk=%0b ext=%0b ka=%0b held=%h",
                   scan_code, is_break, is_extended, key_active, held_code,
                   e.sc, e.brk, e.ext, e.ka, e.held);
          end
        end
      end
    end
  end

  task automatic chk_reset_vals(input string tag);
    @(negedge clk);
    chk({tag, "_sc"},   scan_code, 8'h00);
    chk({tag, "_held"}, held_code, 8'h00);
    chk({tag, "_flags"}, {3'b0, code_valid, is_break, is_extended, frame_err, key_active}, 8'h00);
  endtask

  initial begin
    reset  = 1'b1;
    kb_clk = 1'b1;
    data   = 1'b1;
    tick(4);
    chk_reset_vals("reset");
    reset = 1'b0;
    tick(10);
    chk_reset_vals("post_reset");

    // Make 0x1C
    push_ok(8'h1C, 0, 0, 1, 8'h1C);
    send_frame(8'h1C);
    // Break 0x1C: no pulse on F0 itself
    push_ok(8'h1C, 1, 0, 0, 8'h00);
    send_frame(8'hF0);
    send_frame(8'h1C);

    // Re-make, then bad parity leaves held state untouched
    push_ok(8'h1C, 0, 0, 1, 8'h1C);
    send_frame(8'h1C);
    push_err();
    send_frame(8'h1C, 1);
    @(negedge clk);
    chk("held_after_err", held_code, 8'h1C);
    chk("ka_after_err", {7'b0, key_active}, 8'h01);

    // F0 then bad frame clears break pending; 0x1C is a typematic make
    push_err();
    send_frame(8'hF0);
    send_frame(8'h1C, 1);
    push_ok(8'h1C, 0, 0, 1, 8'h1C);
    send_frame(8'h1C);

    // Bad stop bit
    push_err();
    send_frame(8'h2A, 0, 1);

    // Timeout: start + 4 bits then idle
    push_err();
    send_bit(1'b0, 0);
    for (int i = 0; i < 4; i++) send_bit(i[0], 0);
    data = 1'b1;
    tick(5000);
    push_ok(8'h1B, 0, 0, 1, 8'h1B);
    send_frame(8'h1B);

    // Extended make and break leave held state alone
    push_ok(8'h75, 0, 1, 1, 8'h1B);
    send_frame(8'hE0);
    send_frame(8'h75);
    push_ok(8'h75, 1, 1, 1, 8'h1B);
    send_frame(8'hE0);
    send_frame(8'hF0);
    send_frame(8'h75);

    // Break of a key that is not held: no change
    push_ok(8'h1C, 1, 0, 1, 8'h1B);
    send_frame(8'hF0);
    send_frame(8'h1C);

    // Glitched frames: break of held 0x1B
    push_ok(8'h1B, 1, 0, 0, 8'h00);
    send_frame(8'hF0, 0, 0, 1);
    send_frame(8'h1B, 0, 0, 1);

    // Make 0x23, then reset mid-frame
    push_ok(8'h23, 0, 0, 1, 8'h23);
    send_frame(8'h23);
    send_bit(1'b0, 0);
    for (int i = 0; i < 5; i++) send_bit(1'b1, 0);
    reset = 1'b1;
    tick(3);
    chk_reset_vals("mid_reset");
    reset = 1'b0;
    tick(10);
    chk_reset_vals("after_mid_reset");
    push_ok(8'h1C, 0, 0, 1, 8'h1C);
    send_frame(8'h1C);

    tick(200);
    chk("sb_empty", 8'(sb.size()), 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
